chdr_framing_guard: RTL and testbench

//  Ingress guard on the host->crossbar path (data mover h2s stream -> crossbar port 0).

---
 rtl/chdr_pkg.sv | 33 +++
 rtl/chdr_guard_skid.sv | 75 +++++++
 rtl/chdr_framing_guard.sv | 222 ++++++++++++++++++++++
 tb/tb_chdr_framing_guard.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chdr_pkg.sv
// ---------------------------------------------------------------------------------------------
// chdr_pkg
// Shared definitions for the CHDR framing guard: header length field location, guard FSM
// state encoding and the header-length-to-beat-count helper.
// ---------------------------------------------------------------------------------------------
package chdr_pkg;

  // CHDR header length field (bytes, header included)
  localparam int unsigned CHDR_LEN_HI = 47;
  localparam int unsigned CHDR_LEN_LO = 32;

  localparam int unsigned CHDR_W = 64;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,  // next accepted beat is a header
    ST_PASS    = 2'd1,  // forwarding payload of an in-range packet
    ST_DISCARD = 2'd2,  // sinking the tail of an overlong packet
    ST_DROP    = 2'd3   // sinking an oversize packet whole
  } state_e;

  // Number of 64-bit beats implied by a byte length. Evaluated in 17 bits so that
  // len = 16'hFFFF rounds up without wrapping. A zero length still occupies the
  // header beat, so it is treated as one beat.
  function automatic logic [16:0] chdr_exp_beats(input logic [15:0] len);
    logic [16:0] beats;
    beats = ({1'b0, len} + 17'd7) >> 3;
    if (beats == 17'd0) begin
      beats = 17'd1;
    end
    return beats;
  endfunction

endpackage

// File: rtl/chdr_guard_skid.sv
// ---------------------------------------------------------------------------------------------
// chdr_guard_skid
// Two-entry skid register between the guard FSM and the crossbar. A pushed word appears on
// the output one cycle later; a simultaneous push and pop keeps one word in flight, so the
// stream runs at full throughput. The head word is held stable while o_valid && !i_ready.
//
// Ports
//   bus_clk    in   1   clock
//   bus_rst_n  in   1   synchronous reset, active low (empties the buffer)
//   clear      in   1   synchronous flush
//   i_data     in   W   word to push
//   i_valid    in   1   push request (ignored while full)
//   o_full     out  1   both entries occupied
//   o_data     out  W   head word
//   o_valid    out  1   head word present
//   i_ready    in   1   downstream ready (pops the head word)
// ---------------------------------------------------------------------------------------------
module chdr_guard_skid #(
  parameter int unsigned W = 65
) (
  input  logic         bus_clk,
  input  logic         bus_rst_n,
  input  logic         clear,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_full,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [1:0]   r_cnt;
  logic [W-1:0] r_ent0;  // head entry, drives o_data
  logic [W-1:0] r_ent1;  // skid entry, only used while downstream stalls

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_ent0;

  assign w_push = i_valid && !o_full;
  assign w_pop  = o_valid && i_ready;

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n || clear) begin
      r_cnt <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_ent0 <= i_data;
          end else begin
            r_ent1 <= i_data;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          // When only one word was held, r_ent1 is stale but r_cnt marks it empty.
          r_ent0 <= r_ent1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Push requires !full and pop requires a word, so exactly one word is held:
          // the incoming word replaces the departing head.
          r_ent0 <= i_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/chdr_framing_guard.sv
// ---------------------------------------------------------------------------------------------
// chdr_framing_guard
// Ingress guard on the host->crossbar CHDR path. Compares each packet's header length
// against its tlast framing:
//   - overlong packets are cut at the header length (tlast forced, tail sunk),
//   - packets longer than 2**MTU beats are dropped whole,
//   - short packets pass unchanged.
// Each event class has its own saturating counter; cnt_pkts counts emitted packets.
//
// Ports
//   bus_clk    in   1      clock
//   bus_rst_n  in   1      synchronous reset, active low
//   clear      in   1      zero counters, return FSM to header state, flush buffer
//   i_tdata    in   64     CHDR stream from the data mover
//   i_tlast    in   1
//   i_tvalid   in   1
//   i_tready   out  1
//   o_tdata    out  64     guarded CHDR stream to the crossbar
//   o_tlast    out  1
//   o_tvalid   out  1
//   o_tready   in   1
//   cnt_pkts   out  32     packets emitted (wrapping)
//   cnt_trunc  out  CNT_W  overlong packets truncated
//   cnt_short  out  CNT_W  packets ending before the header length
//   cnt_drop   out  CNT_W  oversize packets dropped
// ---------------------------------------------------------------------------------------------
module chdr_framing_guard
  import chdr_pkg::*;
#(
  parameter int unsigned MTU   = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             bus_clk,
  input  logic             bus_rst_n,
  input  logic             clear,
  input  logic [63:0]      i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [63:0]      o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [31:0]      cnt_pkts,
  output logic [CNT_W-1:0] cnt_trunc,
  output logic [CNT_W-1:0] cnt_short,
  output logic [CNT_W-1:0] cnt_drop
);

  // Beat counter width: holds 1..2**MTU. Oversize packets never reach ST_PASS, so the
  // counter cannot wrap.
  localparam int unsigned BC_W = MTU + 1;
  localparam logic [16:0] MAX_BEATS = 17'(1 << MTU);

  // Registered state
  state_e            r_state;
  logic [BC_W-1:0]   r_bc;
  logic [BC_W-1:0]   r_exp;
  logic [31:0]       r_cnt_pkts;
  logic [CNT_W-1:0]  r_cnt_trunc;
  logic [CNT_W-1:0]  r_cnt_short;
  logic [CNT_W-1:0]  r_cnt_drop;

  // Header decode
  logic [15:0]       w_len;
  logic [16:0]       w_exp17;
  logic              w_oversize;

  // Handshake
  logic              w_sink;
  logic              w_full;
  logic              w_acc;
  logic              w_sk_valid;
  logic [CHDR_W:0]   w_sk_data;

  // Next-state decode
  state_e            w_state_d;
  logic [BC_W-1:0]   w_bc_d;
  logic [BC_W-1:0]   w_exp_d;
  logic [BC_W-1:0]   w_bc_nxt;
  logic              w_push;
  logic              w_push_last;
  logic              w_inc_trunc;
  logic              w_inc_short;
  logic              w_inc_drop;

  assign w_len      = i_tdata[CHDR_LEN_HI:CHDR_LEN_LO];
  assign w_exp17    = chdr_exp_beats(w_len);
  assign w_oversize = (w_exp17 > MAX_BEATS);

  // Sinking states never touch the buffer, so they accept every cycle regardless of
  // downstream backpressure.
  assign w_sink   = (r_state == ST_DISCARD) || (r_state == ST_DROP);
  assign i_tready = bus_rst_n && (w_sink || !w_full);

  // A beat arriving with clear is abandoned along with the rest of the packet.
  assign w_acc    = i_tvalid && i_tready && !clear;

  assign w_bc_nxt = r_bc + BC_W'(1);

  always_comb begin
    w_state_d   = r_state;
    w_bc_d      = r_bc;
    w_exp_d     = r_exp;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_inc_trunc = 1'b0;
    w_inc_short = 1'b0;
    w_inc_drop  = 1'b0;

    if (w_acc) begin
      unique case (r_state)
        ST_HDR: begin
          if (w_oversize) begin
            w_inc_drop = 1'b1;
            w_state_d  = i_tlast ? ST_HDR : ST_DROP;
          end else begin
            w_push  = 1'b1;
            w_bc_d  = BC_W'(1);
            w_exp_d = w_exp17[BC_W-1:0];
            if (w_exp17 == 17'd1) begin
              // Single-beat packet: the header itself is the last beat.
              w_push_last = 1'b1;
              if (!i_tlast) begin
                w_inc_trunc = 1'b1;
                w_state_d   = ST_DISCARD;
              end
            end else if (i_tlast) begin
              w_push_last = 1'b1;
              w_inc_short = 1'b1;
            end else begin
              w_state_d = ST_PASS;
            end
          end
        end

        ST_PASS: begin
          w_push = 1'b1;
          w_bc_d = w_bc_nxt;
          if (w_bc_nxt == r_exp) begin
            w_push_last = 1'b1;
            if (i_tlast) begin
              w_state_d = ST_HDR;
            end else begin
              w_inc_trunc = 1'b1;
              w_state_d   = ST_DISCARD;
            end
          end else if (i_tlast) begin
            w_push_last = 1'b1;
            w_inc_short = 1'b1;
            w_state_d   = ST_HDR;
          end
        end

        ST_DISCARD, ST_DROP: begin
          if (i_tlast) begin
            w_state_d = ST_HDR;
          end
        end

        default: begin
          w_state_d = ST_HDR;
        end
      endcase
    end
  end

  // FSM and counters. Reset and clear take priority over any same-cycle event.
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n || clear) begin
      r_state     <= ST_HDR;
      r_bc        <= '0;
      r_exp       <= '0;
      r_cnt_pkts  <= '0;
      r_cnt_trunc <= '0;
      r_cnt_short <= '0;
      r_cnt_drop  <= '0;
    end else begin
      r_state <= w_state_d;
      r_bc    <= w_bc_d;
      r_exp   <= w_exp_d;

      if (w_push && w_push_last) begin
        r_cnt_pkts <= r_cnt_pkts + 32'd1;
      end
      if (w_inc_trunc && (r_cnt_trunc != '1)) begin
        r_cnt_trunc <= r_cnt_trunc + CNT_W'(1);
      end
      if (w_inc_short && (r_cnt_short != '1)) begin
        r_cnt_short <= r_cnt_short + CNT_W'(1);
      end
      if (w_inc_drop && (r_cnt_drop != '1)) begin
        r_cnt_drop <= r_cnt_drop + CNT_W'(1);
      end
    end
  end

  chdr_guard_skid #(
    .W (CHDR_W + 1)
  ) u_skid (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .clear     (clear),
    .i_data    ({w_push_last, i_tdata}),
    .i_valid   (w_push),
    .o_full    (w_full),
    .o_data    (w_sk_data),
    .o_valid   (w_sk_valid),
    .i_ready   (o_tready)
  );

  // Output is forced idle while reset is asserted.
  assign o_tvalid  = w_sk_valid && bus_rst_n;
  assign o_tlast   = w_sk_data[CHDR_W];
  assign o_tdata   = w_sk_data[CHDR_W-1:0];

  assign cnt_pkts  = r_cnt_pkts;
  assign cnt_trunc = r_cnt_trunc;
  assign cnt_short = r_cnt_short;
  assign cnt_drop  = r_cnt_drop;

endmodule

// File: tb/tb_chdr_framing_guard.sv
// ---------------------------------------------------------------------------------------------
// tb_chdr_framing_guard
// Directed vector table, reset/clear sequences and a randomized run against a packet-level
// reference model. A narrow error counter width is used so saturation is reachable.
// ---------------------------------------------------------------------------------------------
module tb_chdr_framing_guard;

  localparam int unsigned MTU   = 10;
  localparam int unsigned CNT_W = 3;
  localparam int          MAXB  = 1024;
  localparam int          SAT   = 7;

  logic             bus_clk = 1'b0;
  logic             bus_rst_n;
  logic             clear;
  logic [63:0]      i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic [63:0]      o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;
  logic [31:0]      cnt_pkts;
  logic [CNT_W-1:0] cnt_trunc;
  logic [CNT_W-1:0] cnt_short;
  logic [CNT_W-1:0] cnt_drop;

  always #5 bus_clk = ~bus_clk;

  chdr_framing_guard #(
    .MTU   (MTU),
    .CNT_W (CNT_W)
  ) dut (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .clear     (clear),
    .i_tdata   (i_tdata),
    .i_tlast   (i_tlast),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .cnt_pkts  (cnt_pkts),
    .cnt_trunc (cnt_trunc),
    .cnt_short (cnt_short),
    .cnt_drop  (cnt_drop)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state (written only by the monitor)
  int          neg_cyc    = 0;
  logic [64:0] out_q[$];
  int          out_cyc_q[$];
  int          stall_cnt  = 0;
  int          stall_viol = 0;
  int          stall_seen = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_out   = '0;

  bit          rand_ready = 1'b0;
  logic [63:0] pkt[$];

  always @(negedge bus_clk) begin
    neg_cyc <= neg_cyc + 1;
    if (prev_stall) begin
      stall_seen <= stall_seen + 1;
      if (!(o_tvalid && ({o_tlast, o_tdata} == prev_out))) stall_viol <= stall_viol + 1;
    end
    prev_stall <= o_tvalid && !o_tready && bus_rst_n && !clear;
    prev_out   <= {o_tlast, o_tdata};
    if (o_tvalid && o_tready) begin
      out_q.push_back({o_tlast, o_tdata});
      out_cyc_q.push_back(neg_cyc);
    end
    if (i_tvalid && !i_tready && bus_rst_n) stall_cnt <= stall_cnt + 1;
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge bus_clk);
      #1;
      o_tready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge bus_clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, output int acc_cyc);
    bit acc = 1'b0;
    acc_cyc  = -1;
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    for (int k = 0; k < 400 && !acc; k++) begin
      @(negedge bus_clk);
      if (i_tready) begin
        acc     = 1'b1;
        acc_cyc = neg_cyc;
      end
      @(posedge bus_clk);
      #1;
    end
    i_tvalid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no i_tready, expected accept within 400 cycles");
    end
  endtask

  task automatic build_pkt(input logic [15:0] len, input int n, input int tag);
    pkt.delete();
    pkt.push_back({8'hC0, 8'(tag), len, 32'(tag) * 32'h0101_0101});
    for (int i = 1; i < n; i++) pkt.push_back({$urandom, $urandom});
  endtask

  task automatic send_pkt(input bit gaps, output int hdr_cyc);
    int c;
    hdr_cyc = -1;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps && ($urandom % 4 == 0)) idle(1);
      send_beat(pkt[i], (i == pkt.size() - 1), c);
      if (i == 0) hdr_cyc = c;
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge bus_clk);
      if (!o_tvalid) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got o_tvalid stuck high, expected drain in 2000 cycles");
    end
    @(posedge bus_clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge bus_clk);
    #1;
    clear = 1'b0;
  endtask

  typedef struct {
    logic [15:0] len;
    int          n;
    int          nout;
    int          pkts;
    int          trunc;
    int          shrt;
    int          drop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int base, s0, hdr_cyc, nact, errs, c;
    logic [63:0] h;

    //            len        n     nout  pkts trunc shrt drop
    vecs[0] = '{16'd24,     3,    3,    1,   0,    0,   0};  // exact 3-beat packet
    vecs[1] = '{16'd16,     5,    2,    1,   1,    0,   0};  // overlong, truncated
    vecs[2] = '{16'd40,     2,    2,    1,   0,    1,   0};  // short
    vecs[3] = '{16'd8,      1,    1,    1,   0,    0,   0};  // single beat
    vecs[4] = '{16'hFFFF,   20,   0,    0,   0,    0,   1};  // oversize, dropped
    vecs[5] = '{16'd8192,   1024, 1024, 1,   0,    0,   0};  // exactly MTU beats
    vecs[6] = '{16'd8193,   3,    0,    0,   0,    0,   1};  // one beat over MTU
    vecs[7] = '{16'd0,      3,    1,    1,   1,    0,   0};  // zero length counts as 1
    vecs[8] = '{16'd9,      2,    2,    1,   0,    0,   0};  // rounding up

    bus_rst_n = 1'b0;
    clear     = 1'b0;
    i_tvalid  = 1'b0;
    i_tdata   = '0;
    i_tlast   = 1'b0;
    idle(3);

    // Reset state
    @(negedge bus_clk);
    check("reset_o_tvalid", 64'(o_tvalid), 64'd0);
    check("reset_i_tready", 64'(i_tready), 64'd0);
    check("reset_cnt_pkts", 64'(cnt_pkts), 64'd0);
    check("reset_cnt_errs", 64'({cnt_trunc, cnt_short, cnt_drop}), 64'd0);
    @(posedge bus_clk);
    #1;
    bus_rst_n = 1'b1;
    idle(1);

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      do_clear();
      base = out_q.size();
      s0   = stall_cnt;
      build_pkt(vecs[v].len, vecs[v].n, v);
      send_pkt(1'b0, hdr_cyc);
      drain();
      nact = out_q.size() - base;
      check($sformatf("v%0d_beats", v), 64'(nact), 64'(vecs[v].nout));
      errs = 0;
      for (int i = 0; i < nact && i < vecs[v].nout; i++) begin
        if (out_q[base+i] !== {(i == vecs[v].nout - 1), pkt[i]}) errs++;
      end
      check($sformatf("v%0d_data_last", v), 64'(errs), 64'd0);
      if (vecs[v].nout > 0 && nact > 0) begin
        check($sformatf("v%0d_latency", v), 64'(out_cyc_q[base] - hdr_cyc), 64'd1);
      end
      check($sformatf("v%0d_in_stalls", v), 64'(stall_cnt - s0), 64'd0);
      check($sformatf("v%0d_cnt_pkts", v), 64'(cnt_pkts), 64'(vecs[v].pkts));
      check($sformatf("v%0d_cnt_trunc", v), 64'(cnt_trunc), 64'(vecs[v].trunc));
      check($sformatf("v%0d_cnt_short", v), 64'(cnt_short), 64'(vecs[v].shrt));
      check($sformatf("v%0d_cnt_drop", v), 64'(cnt_drop), 64'(vecs[v].drop));
    end

    // Reset mid-packet: beat 2 presented during reset, beat 3 becomes the new header
    do_clear();
    build_pkt(16'd48, 6, 40);
    pkt[2] = {8'hD0, 8'h02, 16'd24, 32'h0000_0003};
    base = out_q.size();
    send_beat(pkt[0], 1'b0, c);
    i_tdata   = pkt[1];
    i_tlast   = 1'b0;
    i_tvalid  = 1'b1;
    bus_rst_n = 1'b0;
    @(negedge bus_clk);
    check("midrst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("midrst_i_tready", 64'(i_tready), 64'd0);
    @(posedge bus_clk);
    #1;
    bus_rst_n = 1'b1;
    i_tvalid  = 1'b0;
    @(negedge bus_clk);
    check("postrst_o_tvalid", 64'(o_tvalid), 64'd0);
    check("postrst_counters", 64'({cnt_pkts, cnt_trunc, cnt_short, cnt_drop}), 64'd0);
    @(posedge bus_clk);
    #1;
    for (int i = 2; i < 6; i++) send_beat(pkt[i], (i == 5), c);
    drain();
    nact = out_q.size() - base;
    check("postrst_beats", 64'(nact), 64'd3);
    errs = 0;
    for (int i = 0; i < nact && i < 3; i++) begin
      if (out_q[base+i] !== {(i == 2), pkt[i+2]}) errs++;
    end
    check("postrst_data_last", 64'(errs), 64'd0);
    check("postrst_cnt_pkts", 64'(cnt_pkts), 64'd1);
    check("postrst_cnt_trunc", 64'(cnt_trunc), 64'd1);

    // Clear coinciding with a truncation event
    base     = out_q.size();
    i_tdata  = {8'hE0, 8'h01, 16'd8, 32'h0000_0001};
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    clear    = 1'b1;
    @(posedge bus_clk);
    #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    @(negedge bus_clk);
    check("clr_cnt_trunc", 64'(cnt_trunc), 64'd0);
    check("clr_cnt_pkts", 64'(cnt_pkts), 64'd0);
    @(posedge bus_clk);
    #1;
    h = {8'hE0, 8'h02, 16'd8, 32'h0000_0002};
    send_beat(h, 1'b1, c);
    drain();
    check("clr_next_beats", 64'(out_q.size() - base), 64'd1);
    if (out_q.size() > base) check("clr_next_data", 64'(out_q[base] != {1'b1, h}), 64'd0);
    check("clr_next_cnt_pkts", 64'(cnt_pkts), 64'd1);
    check("clr_next_cnt_trunc", 64'(cnt_trunc), 64'd0);

    // Randomized traffic with random downstream backpressure
    begin
      logic [64:0] exp_q[$];
      int m_pkts = 0, m_tr = 0, m_sh = 0, m_dr = 0;
      int n, e, kind, no, mism;
      logic [15:0] len;
      do_clear();
      base = out_q.size();
      rand_ready = 1'b1;
      for (int p = 0; p < 200; p++) begin
        n    = int'($urandom_range(1, 12));
        kind = int'($urandom % 5);
        case (kind)
          0:       len = 16'(n * 8 - int'($urandom_range(0, 7)));
          1:       len = 16'(int'($urandom_range(1, n)) * 8);
          2:       len = 16'((n + int'($urandom_range(1, 5))) * 8 - 3);
          3:       len = 16'($urandom_range(8193, 65535));
          default: len = 16'($urandom_range(0, 8));
        endcase
        build_pkt(len, n, p);
        e = (int'(len) + 7) / 8;
        if (e == 0) e = 1;
        if (e > MAXB) begin
          m_dr++;
        end else begin
          no = (n < e) ? n : e;
          for (int i = 0; i < no; i++) exp_q.push_back({(i == no - 1), pkt[i]});
          m_pkts++;
          if (n > e) m_tr++;
          else if (n < e) m_sh++;
        end
        send_pkt(1'b1, hdr_cyc);
      end
      drain();
      rand_ready = 1'b0;
      nact = out_q.size() - base;
      check("rand_beats", 64'(nact), 64'(exp_q.size()));
      mism = 0;
      for (int i = 0; i < nact && i < exp_q.size(); i++) begin
        if (out_q[base+i] !== exp_q[i]) begin
          if (mism == 0) $display("first stream difference at beat %0d: got %0h want %0h",
                                  i, out_q[base+i], exp_q[i]);
          mism++;
        end
      end
      check("rand_stream", 64'(mism), 64'd0);
      check("rand_hold_while_stalled", 64'(stall_viol), 64'd0);
      check("rand_stalls_seen", 64'(stall_seen > 0), 64'd1);
      check("rand_cnt_pkts", 64'(cnt_pkts), 64'(m_pkts));
      check("rand_cnt_trunc", 64'(cnt_trunc), 64'((m_tr > SAT) ? SAT : m_tr));
      check("rand_cnt_short", 64'(cnt_short), 64'((m_sh > SAT) ? SAT : m_sh));
      check("rand_cnt_drop", 64'(cnt_drop), 64'((m_dr > SAT) ? SAT : m_dr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
